// File: rtl/pipeline_issue_ctrl_if.sv
// Source/retire handshake bundle for pipeline_issue_ctrl.
// master drives instruction words in and watches retirements; slave is the controller.
interface pipeline_issue_ctrl_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_inst;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_inst;

    modport master (
        output in_valid,
        output in_inst,
        input  in_ready,
        input  out_valid,
        input  out_inst
    );

    modport slave (
        input  in_valid,
        input  in_inst,
        output in_ready,
        output out_valid,
        output out_inst
    );
endinterface

// File: rtl/pipeline_issue_ctrl.sv
// Issue scheduler for a linear STAGES-deep pipeline: input FIFO, per-stage valid tracking,
// stall/flush/drain control. Define PIPE_CTRL_BYPASS_EN to issue straight from in_inst when empty.
module pipeline_issue_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned STAGES     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    pipeline_issue_ctrl_if.slave bus_io,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 drain_i,
    output logic                 issue_valid_o,
    output logic [WIDTH-1:0]     issue_inst_o,
    output logic [STAGES-1:0]    stage_valid_o,
    output logic                 busy_o,
    output logic                 drained_o,
    output logic [15:0]          issue_count_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FullCnt = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;

    logic [WIDTH-1:0]  stage_data_q [STAGES];
    logic [WIDTH-1:0]  stage_data_d [STAGES];
    logic [STAGES-1:0] stage_valid_q, stage_valid_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_inst_q, out_inst_d;
    logic             drained_q, drained_d;
    logic [15:0]      issue_count_q, issue_count_d;

    logic fifo_empty, fifo_full, in_ready, accept, push, pop, bypass, empty_after;
    logic             issue_valid;
    logic [WIDTH-1:0] issue_inst;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FullCnt);
    assign in_ready   = !reset_i && !fifo_full && (state_q != StDrain) && !flush_i;
    assign accept     = bus_io.in_valid && in_ready;
    assign pop        = !fifo_empty && !stall_i && !flush_i;

`ifdef PIPE_CTRL_BYPASS_EN
    assign bypass = fifo_empty && !stall_i && !flush_i && accept;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word goes straight to stage 0 and never occupies a FIFO slot.
    assign push        = accept && !bypass;
    assign issue_valid = pop || bypass;
    assign issue_inst  = pop ? mem_q[rd_ptr_q] : (bypass ? bus_io.in_inst : '0);

    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_data_d  = stage_data_q;
        if (flush_i) begin
            stage_valid_d = '0;
            for (int k = 0; k < STAGES; k++) begin
                stage_data_d[k] = '0;
            end
        end else if (!stall_i) begin
            stage_valid_d   = {stage_valid_q[STAGES-2:0], issue_valid};
            stage_data_d[0] = issue_inst;
            for (int k = 1; k < STAGES; k++) begin
                stage_data_d[k] = stage_data_q[k-1];
            end
        end
    end

    always_comb begin
        out_valid_d   = stage_valid_q[STAGES-1] && !stall_i && !flush_i;
        out_inst_d    = out_valid_d ? stage_data_q[STAGES-1] : out_inst_q;
        issue_count_d = issue_valid ? issue_count_q + 16'd1 : issue_count_q;
    end

    // Idle/drain-exit decisions look at occupancy as it will be after this edge.
    assign empty_after = (cnt_d == '0) && (stage_valid_d == '0);

    always_comb begin
        state_d   = state_q;
        drained_d = 1'b0;
        if (flush_i) begin
            state_d   = StIdle;
            drained_d = (state_q == StDrain);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (drain_i) begin
                        if (accept) begin
                            state_d = StDrain;
                        end else begin
                            drained_d = 1'b1;
                        end
                    end else if (accept) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (drain_i) begin
                        if (empty_after) begin
                            state_d   = StIdle;
                            drained_d = 1'b1;
                        end else begin
                            state_d = StDrain;
                        end
                    end else if (empty_after && !accept) begin
                        state_d = StIdle;
                    end
                end
                StDrain: begin
                    if (empty_after) begin
                        state_d   = StIdle;
                        drained_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            stage_valid_q <= '0;
            stage_data_q  <= '{default: '0};
            out_valid_q   <= 1'b0;
            out_inst_q    <= '0;
            drained_q     <= 1'b0;
            issue_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            out_valid_q   <= out_valid_d;
            out_inst_q    <= out_inst_d;
            drained_q     <= drained_d;
            issue_count_q <= issue_count_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus_io.in_inst;
        end
    end

    assign bus_io.in_ready  = in_ready;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_inst  = out_inst_q;
    assign issue_valid_o    = issue_valid;
    assign issue_inst_o     = issue_inst;
    assign stage_valid_o    = stage_valid_q;
    assign busy_o           = (state_q != StIdle);
    assign drained_o        = drained_q;
    assign issue_count_o    = issue_count_q;

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Directed bench for pipeline_issue_ctrl: a vector table for reset and single-word flow,
// plus hand-written burst, stall, drain, flush and mid-operation reset sequences.
module tb_pipeline_issue_ctrl;

    localparam int W = 8;
    localparam int S = 8;
    localparam int D = 4;

    logic          clk;
    logic          reset;
    logic          stall;
    logic          flush;
    logic          drain;
    logic          issue_valid;
    logic [W-1:0]  issue_inst;
    logic [S-1:0]  stage_valid;
    logic          busy;
    logic          drained;
    logic [15:0]   issue_count;

    pipeline_issue_ctrl_if #(.WIDTH(W)) bus ();

    pipeline_issue_ctrl #(
        .WIDTH      (W),
        .STAGES     (S),
        .FIFO_DEPTH (D)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .bus_io        (bus),
        .stall_i       (stall),
        .flush_i       (flush),
        .drain_i       (drain),
        .issue_valid_o (issue_valid),
        .issue_inst_o  (issue_inst),
        .stage_valid_o (stage_valid),
        .busy_o        (busy),
        .drained_o     (drained),
        .issue_count_o (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [7:0]  inst;
        logic        dr;
        logic        rdy;
        logic        isv;
        logic [7:0]  isi;
        logic [7:0]  sv;
        logic        ov;
        logic [7:0]  oi;
        logic        bsy;
        logic        drd;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [16];
    int   n_checks;
    int   n_errors;

    function automatic vec_t mk(input int rst, iv, inst, dr, rdy, isv, isi, sv, ov, oi, bsy, drd,
                                cnt);
        vec_t v;
        v.rst  = 1'(rst);
        v.iv   = 1'(iv);
        v.inst = 8'(inst);
        v.dr   = 1'(dr);
        v.rdy  = 1'(rdy);
        v.isv  = 1'(isv);
        v.isi  = 8'(isi);
        v.sv   = 8'(sv);
        v.ov   = 1'(ov);
        v.oi   = 8'(oi);
        v.bsy  = 1'(bsy);
        v.drd  = 1'(drd);
        v.cnt  = 16'(cnt);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, wanted 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input int r, iv, inst, st, fl, dr);
        reset        = 1'(r);
        bus.in_valid = 1'(iv);
        bus.in_inst  = 8'(inst);
        stall        = 1'(st);
        flush        = 1'(fl);
        drain        = 1'(dr);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic run_table();
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].inst, 0, 0, tbl[i].dr);
            check($sformatf("row%0d_in_ready", i), bus.in_ready, tbl[i].rdy);
            check($sformatf("row%0d_issue_valid", i), issue_valid, tbl[i].isv);
            check($sformatf("row%0d_issue_inst", i), issue_inst, tbl[i].isi);
            check($sformatf("row%0d_stage_valid", i), stage_valid, tbl[i].sv);
            check($sformatf("row%0d_out_valid", i), bus.out_valid, tbl[i].ov);
            check($sformatf("row%0d_out_inst", i), bus.out_inst, tbl[i].oi);
            check($sformatf("row%0d_busy", i), busy, tbl[i].bsy);
            check($sformatf("row%0d_drained", i), drained, tbl[i].drd);
            check($sformatf("row%0d_issue_count", i), issue_count, tbl[i].cnt);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] bw [5];
        logic [7:0] sw [6];
        logic [7:0] dw [5];
        n_checks = 0;
        n_errors = 0;
        bw = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        sw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        dw = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75};

        // rst iv inst dr | rdy isv isi sv ov oi busy drained count
        tbl[0] = mk(1, 1, 'h55, 0, 0, 0, 'h00, 'h00, 0, 'h00, 0, 0, 0);
        tbl[1] = mk(0, 1, 'h01, 0, 1, 0, 'h00, 'h00, 0, 'h00, 0, 0, 0);
        tbl[2] = mk(0, 0, 'h00, 0, 1, 1, 'h01, 'h00, 0, 'h00, 1, 0, 0);
        for (int k = 0; k < 8; k++) tbl[3+k] = mk(0, 0, 0, 0, 1, 0, 0, 1 << k, 0, 0, 1, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 'h01, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 'h01, 0, 0, 1);
        tbl[13] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 'h01, 0, 0, 1);
        tbl[14] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 'h01, 0, 1, 1);
        tbl[15] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 'h01, 0, 0, 1);

        drive(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        run_table();
        idle(2);

        // Burst: five back-to-back words; the FIFO head is always the previous word.
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, bw[i], 0, 0, 0);
            check("burst_in_ready", bus.in_ready, 1);
            check("burst_issue_valid", issue_valid, i > 0);
            if (i > 0) check("burst_issue_inst", issue_inst, bw[i-1]);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int n = 4; n <= 15; n++) begin
            check("burst_out_valid", bus.out_valid, (n >= 9) && (n <= 13));
            if ((n >= 9) && (n <= 13)) check("burst_out_inst", bus.out_inst, bw[n-9]);
            tick();
        end
        check("burst_issue_count", issue_count, 6);
        check("burst_busy", busy, 0);
        idle(2);

        // Stall: A,B in flight, C buffered, three stalled cycles pushing D,E,F.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, sw[i], 0, 0, 0);
            tick();
        end
        check("stall_pre_stage_valid", stage_valid, 8'h03);
        for (int s = 0; s < 3; s++) begin
            drive(0, 1, sw[3+s], 1, 0, 0);
            check("stall_stage_valid", stage_valid, 8'h03);
            check("stall_out_valid", bus.out_valid, 0);
            check("stall_issue_valid", issue_valid, 0);
            check("stall_in_ready", bus.in_ready, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        check("stall_full_in_ready", bus.in_ready, 0);
        check("stall_resume_issue_valid", issue_valid, 1);
        check("stall_resume_issue_inst", issue_inst, sw[2]);
        tick();
        for (int n = 6; n <= 19; n++) begin
            check("stall_out_valid", bus.out_valid, (n >= 12) && (n <= 17));
            if ((n >= 12) && (n <= 17)) check("stall_out_inst", bus.out_inst, sw[n-12]);
            tick();
        end
        check("stall_issue_count", issue_count, 12);
        idle(2);

        // Drain: three words in the pipe, two buffered during a stall, then a drain pulse.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, dw[i], 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        for (int s = 0; s < 2; s++) begin
            drive(0, 1, dw[3+s], 1, 0, 0);
            check("drain_setup_stage_valid", stage_valid, 8'h07);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1);
        check("drain_req_busy", busy, 1);
        check("drain_req_in_ready", bus.in_ready, 1);
        check("drain_req_issue_inst", issue_inst, dw[3]);
        tick();
        for (int n = 6; n <= 17; n++) begin
            if (n == 6) drive(0, 1, 'hEE, 0, 0, 0);
            else drive(0, 0, 0, 0, 0, 0);
            check("drain_in_ready", bus.in_ready, n >= 15);
            check("drain_out_valid", bus.out_valid, (n >= 11) && (n <= 15));
            if ((n >= 11) && (n <= 15)) check("drain_out_inst", bus.out_inst, dw[n-11]);
            check("drain_drained", drained, n == 15);
            check("drain_busy", busy, n < 15);
            tick();
        end
        check("drain_issue_count", issue_count, 17);
        idle(2);

        // Flush: pipe full of 0x30.., FIFO full, then a one-cycle flush.
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 'h30 + i, 0, 0, 0);
            check("flush_fill_in_ready", bus.in_ready, 1);
            tick();
        end
        for (int s = 0; s < 3; s++) begin
            drive(0, 1, 'h39 + s, 1, 0, 0);
            check("flush_fill_stage_valid", stage_valid, 8'hFF);
            check("flush_fill_out_valid", bus.out_valid, 0);
            tick();
        end
        drive(0, 1, 'hEE, 0, 1, 0);
        check("flush_pre_stage_valid", stage_valid, 8'hFF);
        check("flush_in_ready", bus.in_ready, 0);
        check("flush_issue_valid", issue_valid, 0);
        check("flush_pre_issue_count", issue_count, 25);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("flush_stage_valid", stage_valid, 0);
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_post_in_ready", bus.in_ready, 1);
        check("flush_busy", busy, 0);
        check("flush_issue_count", issue_count, 25);
        check("flush_issue_valid_after", issue_valid, 0);
        for (int n = 0; n < 12; n++) begin
            tick();
            check("flush_no_retire", bus.out_valid, 0);
        end

        // Mid-operation reset during a burst, then the single-word table again.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 'hA1 + i, 0, 0, 0);
            tick();
        end
        check("midreset_pre_busy", busy, 1);
        drive(1, 1, 'hA4, 0, 0, 0);
        check("midreset_in_ready", bus.in_ready, 0);
        tick();
        run_table();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
